// File: rtl/sound_pkg.sv
// sound_pkg: shared types and register field positions for the sound
// output path.
//   sample_t          - 4-bit two's-complement channel sample (-8..+7)
//   NR50/NR51/NR52_*  - bit positions of the volume, panning and master fields
//   SOUNDBIAS_DEFAULT - nominal DC bias (mid-scale of the 10-bit level)
//   clamp_level()     - saturates a signed intermediate into 0..1023
package sound_pkg;

  typedef logic signed [3:0] sample_t;

  localparam int NR50_VL_LSB     = 4;
  localparam int NR50_VR_LSB     = 0;
  localparam int NR50_VOL_W      = 3;
  localparam int NR51_LEFT_LSB   = 4;
  localparam int NR51_RIGHT_LSB  = 0;
  localparam int NR52_MASTER_BIT = 7;

  localparam logic [9:0] SOUNDBIAS_DEFAULT = 10'h200;

  localparam logic signed [11:0] LEVEL_MAX = 12'sd1023;

  function automatic logic [9:0] clamp_level(input logic signed [11:0] raw);
    if (raw < 12'sd0) begin
      return 10'd0;
    end else if (raw > LEVEL_MAX) begin
      return 10'h3FF;
    end else begin
      return raw[9:0];
    end
  endfunction

endpackage

// File: rtl/sound_side_mix.sv
// sound_side_mix: purely combinational mix for one stereo side.
//   ch1..ch4      - signed channel samples
//   enables       - per-channel enable for this side, bit 0 = ch1
//   volume        - 3-bit master volume V, gain is V+1
//   master_enable - forces the channel sum to zero when low
//   bias          - unsigned DC offset added after scaling
//   level         - clamped 10-bit output level
module sound_side_mix
  import sound_pkg::*;
(
  input  sample_t    ch1,
  input  sample_t    ch2,
  input  sample_t    ch3,
  input  sample_t    ch4,
  input  logic [3:0] enables,
  input  logic [2:0] volume,
  input  logic       master_enable,
  input  logic [9:0] bias,
  output logic [9:0] level
);

  sample_t           samples [4];
  logic signed [6:0] terms   [4];
  logic signed [6:0] sum;
  logic        [3:0] vol_plus;
  logic signed [9:0] scaled;
  logic signed [11:0] raw;

  assign samples[0] = ch1;
  assign samples[1] = ch2;
  assign samples[2] = ch3;
  assign samples[3] = ch4;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_term
      assign terms[gi] = (master_enable && enables[gi]) ? 7'(samples[gi]) : 7'sd0;
    end
  endgenerate

  // Four samples in -8..+7 fit in 7 bits (-32..+28); times 1..8 fits in
  // 10 bits (-256..+224); adding a 10-bit unsigned bias needs 12 signed bits,
  // so nothing wraps before the clamp even at full scale.
  assign sum      = terms[0] + terms[1] + terms[2] + terms[3];
  assign vol_plus = {1'b0, volume} + 4'd1;
  assign scaled   = 10'(sum) * $signed({6'b0, vol_plus});
  assign raw      = 12'(scaled) + $signed({2'b0, bias});
  assign level    = clamp_level(raw);

endmodule

// File: rtl/sound_pwm_mixer.sv
// sound_pwm_mixer: mixes the four channel samples per stereo side and drives
// one PWM bitstream per side.
//   system_clock   - sole clock
//   reset          - synchronous, active-high
//   ch1..ch4       - signed channel samples, held stable across the boundary
//   NR50/NR51/NR52 - volume, panning and master enable registers
//   SOUNDBIAS      - unsigned DC bias
//   pwm_left/right - PWM bitstreams, high for duty of 2^PWM_BITS cycles
//   sample_strobe  - high while the period counter is 0 (period start)
//   level_left/right - clamped levels latched for the current period
// PWM_BITS is legal in 6..10.
module sound_pwm_mixer
  import sound_pkg::*;
#(
  parameter int PWM_BITS = 9
) (
  input  logic       system_clock,
  input  logic       reset,
  input  sample_t    ch1,
  input  sample_t    ch2,
  input  sample_t    ch3,
  input  sample_t    ch4,
  input  logic [7:0] NR50,
  input  logic [7:0] NR51,
  input  logic [7:0] NR52,
  input  logic [9:0] SOUNDBIAS,
  output logic       pwm_left,
  output logic       pwm_right,
  output logic       sample_strobe,
  output logic [9:0] level_left,
  output logic [9:0] level_right
);

  logic [PWM_BITS-1:0] count_reg;
  logic                at_boundary;
  logic                unused_bits;

  // The counter is a full power of two wide, so M -> 0 is a natural wrap.
  assign at_boundary   = (count_reg == {PWM_BITS{1'b1}});
  assign sample_strobe = (count_reg == '0);
  assign unused_bits   = ^{NR50[7], NR50[3], NR52[6:0]};

  always_ff @(posedge system_clock) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + PWM_BITS'(1);
    end
  end

  // Side 0 is left, side 1 is right.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      localparam int EN_LSB  = (gi == 0) ? NR51_LEFT_LSB : NR51_RIGHT_LSB;
      localparam int VOL_LSB = (gi == 0) ? NR50_VL_LSB   : NR50_VR_LSB;

      logic [9:0]          level_next;
      logic [9:0]          level_reg;
      logic [PWM_BITS-1:0] duty_reg;
      logic                pwm;

      sound_side_mix u_mix (
        .ch1           (ch1),
        .ch2           (ch2),
        .ch3           (ch3),
        .ch4           (ch4),
        .enables       (NR51[EN_LSB +: 4]),
        .volume        (NR50[VOL_LSB +: NR50_VOL_W]),
        .master_enable (NR52[NR52_MASTER_BIT]),
        .bias          (SOUNDBIAS),
        .level         (level_next)
      );

      // Level and duty only move on the period boundary, so every period
      // is generated from one consistent snapshot of the inputs.
      always_ff @(posedge system_clock) begin
        if (reset) begin
          level_reg <= '0;
          duty_reg  <= '0;
        end else if (at_boundary) begin
          level_reg <= level_next;
          duty_reg  <= level_next[9 -: PWM_BITS];
        end
      end

      // Duty never exceeds M, so the output always has at least one low cycle.
      assign pwm = (count_reg < duty_reg);
    end
  endgenerate

  assign pwm_left    = g_side[0].pwm;
  assign pwm_right   = g_side[1].pwm;
  assign level_left  = g_side[0].level_reg;
  assign level_right = g_side[1].level_reg;

endmodule

// File: tb/tb_sound_pwm_mixer.sv
module tb_sound_pwm_mixer;
  import sound_pkg::*;

  localparam int PERIOD = 512;
  localparam int WAIT_LIMIT = 1100;

  logic       system_clock = 1'b0;
  logic       reset;
  sample_t    ch1, ch2, ch3, ch4;
  logic [7:0] NR50, NR51, NR52;
  logic [9:0] SOUNDBIAS;
  logic       pwm_left, pwm_right, sample_strobe;
  logic [9:0] level_left, level_right;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    string      name;
    logic [3:0] c1, c2, c3, c4;
    logic [7:0] n50, n51, n52;
    logic [9:0] bias;
    logic [9:0] exp_l, exp_r;
    int         hi_l, hi_r;
  } vec_t;

  always #5 system_clock = ~system_clock;

  sound_pwm_mixer #(.PWM_BITS(9)) dut (
    .system_clock  (system_clock),
    .reset         (reset),
    .ch1           (ch1),
    .ch2           (ch2),
    .ch3           (ch3),
    .ch4           (ch4),
    .NR50          (NR50),
    .NR51          (NR51),
    .NR52          (NR52),
    .SOUNDBIAS     (SOUNDBIAS),
    .pwm_left      (pwm_left),
    .pwm_right     (pwm_right),
    .sample_strobe (sample_strobe),
    .level_left    (level_left),
    .level_right   (level_right)
  );

  task automatic set_inputs(input vec_t v);
    ch1 = v.c1; ch2 = v.c2; ch3 = v.c3; ch4 = v.c4;
    NR50 = v.n50; NR51 = v.n51; NR52 = v.n52;
    SOUNDBIAS = v.bias;
  endtask

  // Advance at least one cycle, then stop on the negedge where the strobe is seen.
  task automatic next_strobe();
    int k;
    @(negedge system_clock);
    k = 0;
    while (!sample_strobe && k < WAIT_LIMIT) begin
      @(negedge system_clock);
      k++;
    end
    n_compared++;
    if (sample_strobe !== 1'b1) begin
      n_mismatched++;
      $display("FAIL strobe_wait: no sample_strobe within %0d cycles, got %b want 1", WAIT_LIMIT, sample_strobe);
    end
  endtask

  // Count high cycles over one full period starting at the current negedge.
  task automatic measure_period(output int hl, output int hr);
    hl = 0; hr = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (pwm_left)  hl++;
      if (pwm_right) hr++;
      @(negedge system_clock);
    end
  endtask

  task automatic capture(input vec_t v, output logic [9:0] lv_l, output logic [9:0] lv_r,
                         output int hl, output int hr);
    set_inputs(v);
    next_strobe();
    lv_l = level_left;
    lv_r = level_right;
    measure_period(hl, hr);
    $display("%s: level L=%0d R=%0d high L=%0d R=%0d", v.name, lv_l, lv_r, hl, hr);
  endtask

  // From a negedge where reset has just dropped, count cycles to the first
  // strobe and any pwm activity before it.
  task automatic wait_first_capture(output int n, output int highs);
    n = 0; highs = 0;
    while (!(n > 0 && sample_strobe) && n < WAIT_LIMIT) begin
      if (pwm_left || pwm_right) highs++;
      @(negedge system_clock);
      n++;
    end
  endtask

  function automatic vec_t pos_vec();
    vec_t v;
    v = '{"pos", 4'h1, 4'h0, 4'h0, 4'h0, 8'h77, 8'h11, 8'h80, SOUNDBIAS_DEFAULT,
          10'd520, 10'd520, 260, 260};
    return v;
  endfunction

  task automatic test_reset();
    int n, highs, hl, hr;
    set_inputs(pos_vec());
    reset = 1'b1;
    repeat (3) @(negedge system_clock);
    n_compared++;
    if ({sample_strobe, pwm_left, pwm_right} !== 3'b100) begin
      n_mismatched++;
      $display("FAIL reset_ctrl: strobe/pwmL/pwmR got %b want 100", {sample_strobe, pwm_left, pwm_right});
    end
    n_compared++;
    if ({level_left, level_right} !== 20'd0) begin
      n_mismatched++;
      $display("FAIL reset_level: got L=%0d R=%0d want 0 0", level_left, level_right);
    end
    reset = 1'b0;
    wait_first_capture(n, highs);
    $display("test_reset: first strobe after %0d cycles, highs=%0d", n, highs);
    n_compared++;
    if (n !== PERIOD) begin
      n_mismatched++;
      $display("FAIL reset_first_capture: got %0d cycles want %0d", n, PERIOD);
    end
    n_compared++;
    if (highs !== 0) begin
      n_mismatched++;
      $display("FAIL reset_first_period_low: got %0d high cycles want 0", highs);
    end
    n_compared++;
    if (level_left !== 10'd520) begin
      n_mismatched++;
      $display("FAIL reset_first_level: got %0d want 520", level_left);
    end
    measure_period(hl, hr);
    n_compared++;
    if (hl !== 260 || hr !== 260) begin
      n_mismatched++;
      $display("FAIL reset_first_duty: got L=%0d R=%0d want 260 260", hl, hr);
    end
  endtask

  task automatic run_table(input vec_t v[], input string tag);
    logic [9:0] lv_l, lv_r;
    int hl, hr;
    foreach (v[i]) begin
      capture(v[i], lv_l, lv_r, hl, hr);
      n_compared++;
      if ({lv_l, lv_r} !== {v[i].exp_l, v[i].exp_r}) begin
        n_mismatched++;
        $display("FAIL %s_%s_level: got L=%0d R=%0d want L=%0d R=%0d", tag, v[i].name, lv_l, lv_r, v[i].exp_l, v[i].exp_r);
      end
      n_compared++;
      if (hl !== v[i].hi_l || hr !== v[i].hi_r) begin
        n_mismatched++;
        $display("FAIL %s_%s_duty: got L=%0d R=%0d want L=%0d R=%0d", tag, v[i].name, hl, hr, v[i].hi_l, v[i].hi_r);
      end
    end
  endtask

  task automatic test_single_channel();
    vec_t v[];
    v = new[2];
    v[0] = pos_vec();
    v[1] = '{"neg", 4'hF, 4'h0, 4'h0, 4'h0, 8'h77, 8'h11, 8'h80, 10'h200, 10'd504, 10'd504, 252, 252};
    run_table(v, "single");
  endtask

  task automatic test_clamp();
    vec_t v[];
    v = new[3];
    v[0] = '{"high", 4'h7, 4'h7, 4'h7, 4'h7, 8'h77, 8'hFF, 8'h80, 10'h3FF, 10'd1023, 10'd1023, 511, 511};
    v[1] = '{"low",  4'h8, 4'h8, 4'h8, 4'h8, 8'h77, 8'hFF, 8'h80, 10'h000, 10'd0,    10'd0,    0,   0};
    v[2] = '{"side", 4'h7, 4'h7, 4'h7, 4'h7, 8'h77, 8'hF0, 8'h80, 10'h380, 10'd1023, 10'd896,  511, 448};
    run_table(v, "clamp");
  endtask

  task automatic test_panning();
    vec_t v[];
    v = new[3];
    v[0] = '{"pan",   4'h1, 4'h0, 4'h0, 4'h0, 8'h77, 8'h10, 8'h80, 10'h200, 10'd520, 10'd512, 260, 256};
    v[1] = '{"off",   4'h7, 4'h7, 4'h7, 4'h7, 8'h77, 8'hFF, 8'h00, 10'h200, 10'd512, 10'd512, 256, 256};
    v[2] = '{"mixed", 4'h5, 4'hE, 4'h3, 4'h7, 8'h31, 8'h5A, 8'h80, 10'h200, 10'd544, 10'd522, 272, 261};
    run_table(v, "pan");
  endtask

  task automatic test_mid_period();
    int hl, hr, strobes;
    set_inputs(pos_vec());
    next_strobe();
    hl = 0; strobes = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i == 100) ch1 = 4'hF;
      if (pwm_left) hl++;
      if (sample_strobe) strobes++;
      @(negedge system_clock);
    end
    $display("test_mid_period: highs=%0d strobes=%0d level_after=%0d", hl, strobes, level_left);
    n_compared++;
    if (hl !== 260) begin
      n_mismatched++;
      $display("FAIL mid_unchanged: got %0d high cycles want 260", hl);
    end
    n_compared++;
    if (strobes !== 1 || sample_strobe !== 1'b1) begin
      n_mismatched++;
      $display("FAIL strobe_spacing: got %0d strobes in period, strobe at +512=%b want 1 and 1", strobes, sample_strobe);
    end
    n_compared++;
    if (level_left !== 10'd504) begin
      n_mismatched++;
      $display("FAIL mid_next_level: got %0d want 504", level_left);
    end
    measure_period(hl, hr);
    n_compared++;
    if (hl !== 252) begin
      n_mismatched++;
      $display("FAIL mid_next_duty: got %0d want 252", hl);
    end
  endtask

  task automatic test_reset_mid();
    int n, highs, hl, hr;
    set_inputs(pos_vec());
    next_strobe();
    repeat (300) @(negedge system_clock);
    n_compared++;
    if (level_left !== 10'd520) begin
      n_mismatched++;
      $display("FAIL rmid_before: got level %0d want 520", level_left);
    end
    reset = 1'b1;
    @(negedge system_clock);
    n_compared++;
    if ({sample_strobe, pwm_left, pwm_right, level_left, level_right} !== {3'b100, 20'd0}) begin
      n_mismatched++;
      $display("FAIL rmid_clear: strobe=%b pwm=%b%b L=%0d R=%0d want strobe=1 pwm=00 L=0 R=0",
               sample_strobe, pwm_left, pwm_right, level_left, level_right);
    end
    reset = 1'b0;
    wait_first_capture(n, highs);
    $display("test_reset_mid: first strobe after %0d cycles, highs=%0d", n, highs);
    n_compared++;
    if (n !== PERIOD || highs !== 0) begin
      n_mismatched++;
      $display("FAIL rmid_restart: got %0d cycles %0d highs want %0d cycles 0 highs", n, highs, PERIOD);
    end
    measure_period(hl, hr);
    n_compared++;
    if (hl !== 260 || hr !== 260) begin
      n_mismatched++;
      $display("FAIL rmid_first_duty: got L=%0d R=%0d want 260 260", hl, hr);
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_clamp();
    test_panning();
    test_mid_period();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
